// File: rtl/csoc_uart_cmd_ctrl.sv
// UART command front end for the CSoC: decodes opcode/payload frames, drives test pins,
// generates a gateable/steppable CSoC clock and returns ACK/NACK/read data.
module csoc_uart_cmd_ctrl #(
   parameter int DATA_W  = 8,
   parameter int DIV_W   = 16,
   parameter int DIV_RST = 1,
   parameter int STEP_W  = 8,
   parameter int TIMEOUT = 50000000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              new_rx_data,
   output logic [7:0]        tx_data,
   output logic              new_tx_data,
   input  logic              tx_busy,
   output logic              csoc_clk,
   output logic              csoc_rstn,
   output logic              csoc_test_se,
   output logic              csoc_test_tm,
   output logic              csoc_uart_read,
   output logic [DATA_W-1:0] csoc_data_o,
   input  logic              csoc_uart_write,
   input  logic [DATA_W-1:0] csoc_data_i,
   output logic              busy
);

   localparam int NB      = DATA_W / 8;
   localparam int DIV_NB  = DIV_W / 8;
   localparam int STEP_NB = STEP_W / 8;
   localparam int PAY_NB0 = (NB > DIV_NB) ? NB : DIV_NB;
   localparam int PAY_NB  = (PAY_NB0 > STEP_NB) ? PAY_NB0 : STEP_NB;
   localparam int PAY_W   = PAY_NB * 8;
   localparam int RB_W    = DATA_W + 8;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] PAYLOAD = 3'd1;
   localparam logic [2:0] EXEC    = 3'd2;
   localparam logic [2:0] RESP    = 3'd3;
   localparam logic [2:0] TXWAIT  = 3'd4;

   localparam logic [7:0] OP_CTRL  = 8'h01;
   localparam logic [7:0] OP_DIV   = 8'h02;
   localparam logic [7:0] OP_WRITE = 8'h03;
   localparam logic [7:0] OP_READ  = 8'h04;
   localparam logic [7:0] OP_RUN   = 8'h05;
   localparam logic [7:0] OP_STOP  = 8'h06;
   localparam logic [7:0] OP_STEP  = 8'h07;
   localparam logic [7:0] ACK      = 8'hA5;
   localparam logic [7:0] NACK     = 8'hEE;

   function automatic logic [7:0] pay_len(input logic [7:0] op);
      case (op)
         OP_CTRL:  pay_len = 8'd1;
         OP_DIV:   pay_len = 8'(DIV_NB);
         OP_WRITE: pay_len = 8'(NB);
         OP_STEP:  pay_len = 8'(STEP_NB);
         default:  pay_len = 8'd0;
      endcase
   endfunction

   logic [2:0]        state;
   logic [7:0]        opcode, need, byte_cnt, resp_cnt;
   logic [PAY_W-1:0]  pay;
   logic [TMR_W-1:0]  timer;
   logic [RB_W-1:0]   resp_buf;
   logic              txw_first;
   logic [DIV_W-1:0]  div, div_act, cnt;
   logic              run_mode;
   logic [STEP_W-1:0] step_left;
   logic [DATA_W-1:0] rd_buf;
   logic              rd_valid, write_prev;
   logic              exec_run, exec_stop, exec_step, exec_read, capture;
   logic              clk_active, toggle;

   assign busy       = (state != IDLE);
   assign exec_run   = (state == EXEC) && (opcode == OP_RUN);
   assign exec_stop  = (state == EXEC) && (opcode == OP_STOP);
   assign exec_step  = (state == EXEC) && (opcode == OP_STEP);
   assign exec_read  = (state == EXEC) && (opcode == OP_READ);
   assign capture    = csoc_uart_write && !write_prev;
   // A high phase is always completed, so stopping can only happen on a falling toggle.
   assign clk_active = run_mode || (step_left != '0) || csoc_clk;
   assign toggle     = clk_active && (cnt == div_act - 1'b1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         opcode         <= '0;
         need           <= '0;
         byte_cnt       <= '0;
         resp_cnt       <= '0;
         pay            <= '0;
         timer          <= '0;
         resp_buf       <= '0;
         txw_first      <= 1'b0;
         tx_data        <= '0;
         new_tx_data    <= 1'b0;
         csoc_rstn      <= 1'b0;
         csoc_test_se   <= 1'b0;
         csoc_test_tm   <= 1'b0;
         csoc_uart_read <= 1'b0;
         csoc_data_o    <= '0;
         div            <= DIV_W'(DIV_RST);
      end else begin
         new_tx_data    <= 1'b0;
         csoc_uart_read <= 1'b0;
         case (state)
            IDLE: if (new_rx_data) begin
               opcode   <= rx_data;
               need     <= pay_len(rx_data);
               byte_cnt <= '0;
               pay      <= '0;
               timer    <= '0;
               state    <= (pay_len(rx_data) == 8'd0) ? EXEC : PAYLOAD;
            end
            PAYLOAD: begin
               if (new_rx_data) begin
                  for (int i = 0; i < PAY_NB; i++)
                     if (byte_cnt == 8'(i)) pay[i*8 +: 8] <= rx_data;
                  byte_cnt <= byte_cnt + 8'd1;
                  timer    <= '0;
                  if (byte_cnt == need - 8'd1) state <= EXEC;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  resp_buf <= RB_W'(NACK);
                  resp_cnt <= '0;
                  state    <= RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            EXEC: begin
               resp_buf <= RB_W'(ACK);
               resp_cnt <= '0;
               state    <= RESP;
               case (opcode)
                  OP_CTRL:  {csoc_test_tm, csoc_test_se, csoc_rstn} <= pay[2:0];
                  OP_DIV:   div <= (pay[DIV_W-1:0] == '0) ? DIV_W'(1) : pay[DIV_W-1:0];
                  OP_WRITE: begin
                     csoc_data_o    <= pay[DATA_W-1:0];
                     csoc_uart_read <= 1'b1;
                  end
                  OP_READ: begin
                     resp_buf <= {rd_buf, 7'b0, rd_valid};
                     resp_cnt <= 8'(NB);
                  end
                  OP_RUN, OP_STOP, OP_STEP: begin
                  end
                  default:  resp_buf <= RB_W'(NACK);
               endcase
            end
            RESP: if (!tx_busy) begin
               tx_data     <= resp_buf[7:0];
               new_tx_data <= 1'b1;
               resp_buf    <= resp_buf >> 8;
               txw_first   <= 1'b1;
               state       <= TXWAIT;
            end
            TXWAIT: begin
               if (txw_first) begin
                  txw_first <= 1'b0;
               end else if (!tx_busy) begin
                  if (resp_cnt != 8'd0) begin
                     resp_cnt <= resp_cnt - 8'd1;
                     state    <= RESP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The divider is sampled only at a toggle (or while idle) so a mid-phase change never truncates a phase.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         div_act   <= DIV_W'(DIV_RST);
         csoc_clk  <= 1'b0;
         run_mode  <= 1'b0;
         step_left <= '0;
      end else begin
         if (!clk_active) begin
            cnt     <= '0;
            div_act <= div;
         end else if (toggle) begin
            cnt     <= '0;
            div_act <= div;
            if (csoc_clk) begin
               csoc_clk <= 1'b0;
            end else if (run_mode) begin
               csoc_clk <= 1'b1;
            end else if (step_left != '0) begin
               csoc_clk  <= 1'b1;
               step_left <= step_left - 1'b1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (exec_run) begin
            run_mode  <= 1'b1;
            step_left <= '0;
         end else if (exec_stop) begin
            run_mode  <= 1'b0;
            step_left <= '0;
         end else if (exec_step) begin
            run_mode  <= 1'b0;
            step_left <= pay[STEP_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_buf     <= '0;
         rd_valid   <= 1'b0;
         write_prev <= 1'b0;
      end else begin
         write_prev <= csoc_uart_write;
         if (capture) begin
            rd_buf   <= csoc_data_i;
            rd_valid <= 1'b1;
         end else if (exec_read) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule
